// File: rtl/mul.sv
// Sequential shift-add multiplier. Produces the 2N-bit product of X and Y,
// one partial-product step per clock, and exposes it as {high, res}.
// Shares the start/finished handshake and result split with the sequential
// divider so the ALU can drive both units identically.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; res/high hold the last product
// RUN   | one conditional add per edge, N edges in total
// DONE  | finished pulse cycle; returns to IDLE on the next edge
module mul #(
    parameter int N      = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         start,
    output logic [N-1:0] res,
    output logic [N-1:0] high,
    output logic         busy,
    output logic         finished
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Accumulated partial sum; the multiplicand is kept pre-shifted in a
    // 2N-bit register so each step is a plain add with no variable shifter.
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mc_q, mc_d;
    logic [N-1:0]   mp_q, mp_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;

    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   high_q, high_d;
    logic           busy_q, busy_d;
    logic           fin_q, fin_d;

    logic [N-1:0]   x_mag;
    logic [N-1:0]   y_mag;
    logic           neg_in;
    logic [2*N-1:0] acc_sum;
    logic [2*N-1:0] product;

    // Operand conditioning: magnitudes and result sign for the load edge.
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude 2^(N-1), so no extra bit is needed.
    always_comb begin
        x_mag  = X;
        y_mag  = Y;
        neg_in = 1'b0;
        if (SIGNED) begin
            if (X[N-1]) begin
                x_mag = -X;
            end
            if (Y[N-1]) begin
                y_mag = -Y;
            end
            neg_in = X[N-1] ^ Y[N-1];
        end
    end

    // One shift-add step and the final sign fix-up of the completed sum.
    always_comb begin
        acc_sum = acc_q;
        if (mp_q[0]) begin
            acc_sum = acc_q + mc_q;
        end
        product = neg_q ? -acc_sum : acc_sum;
    end

    // Next-state and datapath update; a start request overrides any state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        res_d   = res_q;
        high_d  = high_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_RUN: begin
                acc_d = acc_sum;
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    {high_d, res_d} = product;
                    fin_d           = 1'b1;
                    busy_d          = 1'b0;
                    state_d         = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (start) begin
            acc_d   = '0;
            mc_d    = {{N{1'b0}}, x_mag};
            mp_d    = y_mag;
            neg_d   = neg_in;
            cnt_d   = CW'(N);
            busy_d  = 1'b1;
            fin_d   = 1'b0;
            state_d = S_RUN;
        end
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            high_q  <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            high_q  <= high_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign res      = res_q;
    assign high     = high_q;
    assign busy     = busy_q;
    assign finished = fin_q;

endmodule
